// File: rtl/pic8259_control_logic.sv
// 8259A control logic: ICW/OCW command decode, INTA acknowledge sequencing,
// vector/CALL byte generation, cascade addressing, EOI and rotation control.
module pic8259_control_logic (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] internal_data_bus,
  input  logic       write_initial_command_word_1,
  input  logic       write_initial_command_word_2_4,
  input  logic       write_operation_control_word_1,
  input  logic       write_operation_control_word_2,
  input  logic       write_operation_control_word_3,
  input  logic       read,
  input  logic       write,
  input  logic       interrupt_acknowledge_n,
  input  logic [7:0] interrupt,
  input  logic [7:0] highest_level_in_service,
  inout  wire  [2:0] cascade_inout,
  inout  wire        slave_program_or_enable_buffer,
  output logic       out_control_logic_data,
  output logic [7:0] control_logic_data,
  output logic       interrupt_to_cpu,
  output logic       level_or_edge_toriggered_config,
  output logic       special_fully_nest_config,
  output logic       enable_read_register,
  output logic       read_register_isr_or_irr,
  output logic [7:0] interrupt_mask,
  output logic [7:0] interrupt_special_mask,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic       freeze,
  output logic       latch_in_service,
  output logic [7:0] clear_interrupt_request
);

  typedef enum logic [1:0] {CMD_READY, WRITE_ICW2, WRITE_ICW3, WRITE_ICW4} cmd_state_t;
  typedef enum logic [1:0] {ACK_IDLE, ACK1, ACK2, ACK3} ack_state_t;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  cmd_state_t cmd_state;
  ack_state_t ack_state;

  // Registered strobe history for edge detection
  logic icw1_q, icw24_q, ocw1_q, ocw2_q, ocw3_q, read_q, inta_q;

  // ICW1 fields
  logic       ic4, sngl, adi;
  logic [2:0] addr_a7_a5;
  // ICW2/ICW3/ICW4
  logic [7:0] icw2, icw3;
  logic       upm, aeoi, ms, buffered;

  logic       special_mask_mode;
  logic       aeoi_rotate;
  logic       poll, poll_read;
  logic [7:0] poll_byte;
  logic [2:0] level;
  logic       sp_q;
  logic [2:0] cascade_q;

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  logic icw1_edge, icw24_edge, ocw1_edge, ocw2_edge, ocw3_edge, read_edge;
  logic inta_fall, inta_rise, final_ack;

  assign icw1_edge  = write_initial_command_word_1   & ~icw1_q;
  assign icw24_edge = write_initial_command_word_2_4 & ~icw24_q;
  assign ocw1_edge  = write_operation_control_word_1 & ~ocw1_q;
  assign ocw2_edge  = write_operation_control_word_2 & ~ocw2_q;
  assign ocw3_edge  = write_operation_control_word_3 & ~ocw3_q;
  assign read_edge  = read & ~read_q;
  assign inta_fall  = ~interrupt_acknowledge_n &  inta_q;
  assign inta_rise  =  interrupt_acknowledge_n & ~inta_q;
  assign final_ack  = upm ? (ack_state == ACK2) : (ack_state == ACK3);

  always_ff @(posedge clock) begin
    // NOTE: every register here uses <= so all state updates from the same edge
    // see pre-edge values, regardless of statement order.
    if (reset) begin
      icw1_q <= 1'b0; icw24_q <= 1'b0; ocw1_q <= 1'b0; ocw2_q <= 1'b0;
      ocw3_q <= 1'b0; read_q <= 1'b0; inta_q <= 1'b1;
      cmd_state <= CMD_READY;
      ack_state <= ACK_IDLE;
      ic4 <= 1'b0; sngl <= 1'b0; adi <= 1'b0; addr_a7_a5 <= 3'd0;
      level_or_edge_toriggered_config <= 1'b0;
      icw2 <= 8'h00; icw3 <= 8'h00;
      upm <= 1'b0; aeoi <= 1'b0; ms <= 1'b0; buffered <= 1'b0;
      special_fully_nest_config <= 1'b0;
      interrupt_mask <= 8'h00;
      special_mask_mode <= 1'b0;
      aeoi_rotate <= 1'b0;
      poll <= 1'b0; poll_read <= 1'b0; poll_byte <= 8'h00;
      read_register_isr_or_irr <= 1'b0;
      interrupt_to_cpu <= 1'b0;
      end_of_interrupt <= 8'h00;
      priority_rotate <= 3'd7;
      freeze <= 1'b0;
      latch_in_service <= 1'b0;
      clear_interrupt_request <= 8'h00;
      level <= 3'd0;
      sp_q <= 1'b0;
      cascade_q <= 3'd0;
    end else begin
      icw1_q  <= write_initial_command_word_1;
      icw24_q <= write_initial_command_word_2_4;
      ocw1_q  <= write_operation_control_word_1;
      ocw2_q  <= write_operation_control_word_2;
      ocw3_q  <= write_operation_control_word_3;
      read_q  <= read;
      inta_q  <= interrupt_acknowledge_n;
      sp_q      <= slave_program_or_enable_buffer;
      cascade_q <= cascade_inout;

      // Pulse outputs fall back to zero unless a command re-asserts them
      end_of_interrupt        <= 8'h00;
      latch_in_service        <= 1'b0;
      clear_interrupt_request <= 8'h00;

      if (icw1_edge) begin
        ic4        <= internal_data_bus[0];
        sngl       <= internal_data_bus[1];
        adi        <= internal_data_bus[2];
        level_or_edge_toriggered_config <= internal_data_bus[3];
        addr_a7_a5 <= internal_data_bus[7:5];
        interrupt_mask    <= 8'h00;
        special_mask_mode <= 1'b0;
        poll      <= 1'b0;
        poll_read <= 1'b0;
        icw3 <= 8'h00;
        upm <= 1'b0; aeoi <= 1'b0; ms <= 1'b0; buffered <= 1'b0;
        special_fully_nest_config <= 1'b0;
        read_register_isr_or_irr <= 1'b0;
        priority_rotate  <= 3'd7;
        end_of_interrupt <= 8'hFF;
        interrupt_to_cpu <= 1'b0;
        freeze    <= 1'b0;
        ack_state <= ACK_IDLE;
        cmd_state <= WRITE_ICW2;
      end else begin
        if (icw24_edge) begin
          case (cmd_state)
            WRITE_ICW2: begin
              icw2 <= internal_data_bus;
              if (!sngl)    cmd_state <= WRITE_ICW3;
              else if (ic4) cmd_state <= WRITE_ICW4;
              else          cmd_state <= CMD_READY;
            end
            WRITE_ICW3: begin
              icw3      <= internal_data_bus;
              cmd_state <= ic4 ? WRITE_ICW4 : CMD_READY;
            end
            WRITE_ICW4: begin
              upm      <= internal_data_bus[0];
              aeoi     <= internal_data_bus[1];
              ms       <= internal_data_bus[2];
              buffered <= internal_data_bus[3];
              special_fully_nest_config <= internal_data_bus[4];
              cmd_state <= CMD_READY;
            end
            default: ;
          endcase
        end

        if (ocw1_edge)
          interrupt_mask <= internal_data_bus;

        if (ocw2_edge) begin
          case (internal_data_bus[7:5])
            3'b001: end_of_interrupt <= highest_level_in_service;
            3'b011: end_of_interrupt <= 8'h01 << internal_data_bus[2:0];
            3'b101: begin
              end_of_interrupt <= highest_level_in_service;
              priority_rotate  <= encode(highest_level_in_service);
            end
            3'b111: begin
              end_of_interrupt <= 8'h01 << internal_data_bus[2:0];
              priority_rotate  <= internal_data_bus[2:0];
            end
            3'b110: priority_rotate <= internal_data_bus[2:0];
            3'b100: aeoi_rotate <= 1'b1;
            3'b000: aeoi_rotate <= 1'b0;
            default: ;
          endcase
        end

        if (ocw3_edge) begin
          if (internal_data_bus[1]) read_register_isr_or_irr <= internal_data_bus[0];
          if (internal_data_bus[2]) poll <= 1'b1;
          if (internal_data_bus[6]) special_mask_mode <= internal_data_bus[5];
        end

        // Poll read behaves like a software acknowledge of the winning request
        if (read_edge && poll) begin
          poll      <= 1'b0;
          poll_read <= 1'b1;
          poll_byte <= {(interrupt != 8'h00), 4'b0000, encode(interrupt)};
          if (interrupt != 8'h00) begin
            latch_in_service        <= 1'b1;
            clear_interrupt_request <= interrupt;
          end
        end else if (!read) begin
          poll_read <= 1'b0;
        end

        if (inta_fall)
          interrupt_to_cpu <= 1'b0;
        else if (interrupt != 8'h00 && cmd_state == CMD_READY && ack_state == ACK_IDLE)
          interrupt_to_cpu <= 1'b1;

        if (inta_fall) begin
          case (ack_state)
            ACK_IDLE: if (cmd_state == CMD_READY) begin
              ack_state               <= ACK1;
              freeze                  <= 1'b1;
              latch_in_service        <= 1'b1;
              clear_interrupt_request <= interrupt;
              level                   <= encode(interrupt);
            end
            ACK1:    ack_state <= ACK2;
            ACK2:    if (!upm) ack_state <= ACK3;
            default: ;
          endcase
        end else if (inta_rise && final_ack) begin
          ack_state <= ACK_IDLE;
          freeze    <= 1'b0;
          if (aeoi) begin
            end_of_interrupt <= 8'h01 << level;
            if (aeoi_rotate) priority_rotate <= level;
          end
        end
      end
    end
  end

  // Inout inputs are sampled through registers to keep the tristate paths loop-free
  logic       master;
  logic       vector_enable;
  logic       ack_drive;
  logic [7:0] ack_byte;
  logic [7:0] mcs_vector;
  logic       cascade_drive;

  assign master        = buffered ? ms : sp_q;
  assign vector_enable = sngl | (master ? ~icw3[level] : (cascade_q == icw3[2:0]));
  assign mcs_vector    = adi ? {addr_a7_a5, level, 2'b00}
                             : {addr_a7_a5[2:1], level, 3'b000};

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    ack_drive = 1'b0;
    ack_byte  = 8'h00;
    case (ack_state)
      ACK1: if (!upm) begin
        ack_drive = sngl | master;
        ack_byte  = CALL_OPCODE;
      end
      ACK2: begin
        ack_drive = vector_enable;
        ack_byte  = upm ? {icw2[7:3], level} : mcs_vector;
      end
      ACK3: begin
        ack_drive = vector_enable;
        ack_byte  = icw2;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_control_logic_data = 1'b0;
    control_logic_data     = 8'h00;
    if (poll_read && read) begin
      out_control_logic_data = 1'b1;
      control_logic_data     = poll_byte;
    end else if (ack_drive && !inta_q) begin
      out_control_logic_data = 1'b1;
      control_logic_data     = ack_byte;
    end
  end

  assign enable_read_register = read & ~write & (cmd_state == CMD_READY) & ~poll
                              & ~poll_read & (ack_state == ACK_IDLE);
  assign interrupt_special_mask = special_mask_mode ? interrupt_mask : 8'h00;

  assign cascade_drive = ~sngl & master & (ack_state != ACK_IDLE) & icw3[level];
  assign cascade_inout = cascade_drive ? level : 3'bzzz;
  assign slave_program_or_enable_buffer = buffered ? ~out_control_logic_data : 1'bz;

endmodule

// File: tb/tb_pic8259_control_logic.sv
// Directed bench for pic8259_control_logic: init sequences, INTA byte streams,
// EOI/rotate commands, cascade addressing, read select, special mask and poll.
module tb_pic8259_control_logic;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] internal_data_bus;
  logic       write_initial_command_word_1, write_initial_command_word_2_4;
  logic       write_operation_control_word_1, write_operation_control_word_2;
  logic       write_operation_control_word_3;
  logic       read, write, interrupt_acknowledge_n;
  logic [7:0] interrupt, highest_level_in_service;
  wire  [2:0] cascade_inout;
  wire        slave_program_or_enable_buffer;
  logic       out_control_logic_data;
  logic [7:0] control_logic_data;
  logic       interrupt_to_cpu, level_or_edge_toriggered_config, special_fully_nest_config;
  logic       enable_read_register, read_register_isr_or_irr;
  logic [7:0] interrupt_mask, interrupt_special_mask, end_of_interrupt;
  logic [2:0] priority_rotate;
  logic       freeze, latch_in_service;
  logic [7:0] clear_interrupt_request;

  logic       cas_en;
  logic [2:0] cas_drv;
  assign cascade_inout = cas_en ? cas_drv : 3'bzzz;
  assign slave_program_or_enable_buffer = 1'b1;

  pic8259_control_logic dut (
    .clock(clock), .reset(reset), .internal_data_bus(internal_data_bus),
    .write_initial_command_word_1(write_initial_command_word_1),
    .write_initial_command_word_2_4(write_initial_command_word_2_4),
    .write_operation_control_word_1(write_operation_control_word_1),
    .write_operation_control_word_2(write_operation_control_word_2),
    .write_operation_control_word_3(write_operation_control_word_3),
    .read(read), .write(write), .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .interrupt(interrupt), .highest_level_in_service(highest_level_in_service),
    .cascade_inout(cascade_inout),
    .slave_program_or_enable_buffer(slave_program_or_enable_buffer),
    .out_control_logic_data(out_control_logic_data), .control_logic_data(control_logic_data),
    .interrupt_to_cpu(interrupt_to_cpu),
    .level_or_edge_toriggered_config(level_or_edge_toriggered_config),
    .special_fully_nest_config(special_fully_nest_config),
    .enable_read_register(enable_read_register),
    .read_register_isr_or_irr(read_register_isr_or_irr),
    .interrupt_mask(interrupt_mask), .interrupt_special_mask(interrupt_special_mask),
    .end_of_interrupt(end_of_interrupt), .priority_rotate(priority_rotate),
    .freeze(freeze), .latch_in_service(latch_in_service),
    .clear_interrupt_request(clear_interrupt_request)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef enum {S_ICW1, S_ICW24, S_OCW1, S_OCW2, S_OCW3} strobe_t;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  // Returns at the negedge right after the acting posedge, so pulses are visible
  task automatic wr(input strobe_t s, input logic [7:0] d);
    tick();
    internal_data_bus = d;
    case (s)
      S_ICW1:  write_initial_command_word_1   = 1'b1;
      S_ICW24: write_initial_command_word_2_4 = 1'b1;
      S_OCW1:  write_operation_control_word_1 = 1'b1;
      S_OCW2:  write_operation_control_word_2 = 1'b1;
      default: write_operation_control_word_3 = 1'b1;
    endcase
    tick();
    write_initial_command_word_1   = 1'b0;
    write_initial_command_word_2_4 = 1'b0;
    write_operation_control_word_1 = 1'b0;
    write_operation_control_word_2 = 1'b0;
    write_operation_control_word_3 = 1'b0;
  endtask

  task automatic inta_low;
    interrupt_acknowledge_n = 1'b0;
    tick();
  endtask

  task automatic inta_high;
    interrupt_acknowledge_n = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    internal_data_bus = 8'h00;
    write_initial_command_word_1 = 1'b0; write_initial_command_word_2_4 = 1'b0;
    write_operation_control_word_1 = 1'b0; write_operation_control_word_2 = 1'b0;
    write_operation_control_word_3 = 1'b0;
    read = 1'b0; write = 1'b0; interrupt_acknowledge_n = 1'b1;
    interrupt = 8'h00; highest_level_in_service = 8'h00;
    cas_en = 1'b1; cas_drv = 3'b101;
    tick(4);
    reset = 1'b0;
    tick();

    // Reset state; cascade must be released so the bench value reads back
    check("rst_mask",   interrupt_mask, 8'h00);
    check("rst_rotate", priority_rotate, 3'd7);
    check("rst_int",    interrupt_to_cpu, 1'b0);
    check("rst_out",    out_control_logic_data, 1'b0);
    check("rst_cas",    cascade_inout, 3'b101);

    // Single MCS-80
    wr(S_ICW1, 8'hF7);
    check("icw1_eoi", end_of_interrupt, 8'hFF);
    wr(S_ICW24, 8'hFF);
    wr(S_ICW24, 8'h00);
    wr(S_OCW1, 8'h00);
    interrupt = 8'h01;
    tick();
    check("mcs_int", interrupt_to_cpu, 1'b1);
    inta_low();
    check("mcs_latch1", latch_in_service, 1'b1);
    check("mcs_clr1",   clear_interrupt_request, 8'h01);
    check("mcs_freeze1", freeze, 1'b1);
    check("mcs_int_clr", interrupt_to_cpu, 1'b0);
    check("mcs_out1",   out_control_logic_data, 1'b1);
    check("mcs_byte1",  control_logic_data, 8'hCD);
    interrupt = 8'h00;
    inta_high();
    check("mcs_latch_once", latch_in_service, 1'b0);
    check("mcs_clr_once",   clear_interrupt_request, 8'h00);
    check("mcs_out_gap",    out_control_logic_data, 1'b0);
    check("mcs_freeze_mid", freeze, 1'b1);
    inta_low();
    check("mcs_byte2", control_logic_data, 8'hE0);
    inta_high();
    inta_low();
    check("mcs_byte3", control_logic_data, 8'hFF);
    inta_high();
    check("mcs_freeze_end", freeze, 1'b0);
    check("mcs_no_aeoi",    end_of_interrupt, 8'h00);

    // OCW2 rotate-on-EOI, then plain EOI
    highest_level_in_service = 8'h01;
    wr(S_OCW2, 8'hA0);
    check("ocw2_rot_eoi", end_of_interrupt, 8'h01);
    check("ocw2_rot",     priority_rotate, 3'd0);
    tick();
    check("ocw2_eoi_pulse", end_of_interrupt, 8'h00);
    highest_level_in_service = 8'h08;
    wr(S_OCW2, 8'h20);
    check("ocw2_eoi",     end_of_interrupt, 8'h08);
    check("ocw2_rot_hold", priority_rotate, 3'd0);
    highest_level_in_service = 8'h00;

    // 8086 mode
    wr(S_ICW1, 8'h17);
    check("x86_rot_reset", priority_rotate, 3'd7);
    wr(S_ICW24, 8'hF8);
    wr(S_ICW24, 8'h01);
    interrupt = 8'h08;
    tick();
    check("x86_int", interrupt_to_cpu, 1'b1);
    inta_low();
    check("x86_out1", out_control_logic_data, 1'b0);
    check("x86_clr1", clear_interrupt_request, 8'h08);
    interrupt = 8'h00;
    inta_high();
    inta_low();
    check("x86_out2",  out_control_logic_data, 1'b1);
    check("x86_byte2", control_logic_data, 8'hFB);
    inta_high();
    check("x86_freeze_end", freeze, 1'b0);

    // Cascade master: ICW2, ICW3, ICW4 all required before commands are ready
    wr(S_ICW1, 8'hF5);
    wr(S_ICW24, 8'hFF);
    read = 1'b1;
    wr(S_ICW24, 8'hFF);
    check("cas_not_ready", enable_read_register, 1'b0);
    wr(S_ICW24, 8'h00);
    check("cas_ready", enable_read_register, 1'b1);
    read = 1'b0;
    cas_en = 1'b0;
    interrupt = 8'h04;
    tick();
    inta_low();
    check("cas_out1",  out_control_logic_data, 1'b1);
    check("cas_byte1", control_logic_data, 8'hCD);
    check("cas_id1",   cascade_inout, 3'b010);
    interrupt = 8'h00;
    inta_high();
    inta_low();
    check("cas_out2", out_control_logic_data, 1'b0);
    check("cas_id2",  cascade_inout, 3'b010);
    inta_high();
    inta_low();
    check("cas_out3", out_control_logic_data, 1'b0);
    inta_high();
    check("cas_freeze_end", freeze, 1'b0);
    cas_en = 1'b1;
    cas_drv = 3'b101;
    tick();
    check("cas_released", cascade_inout, 3'b101);

    // Read select and special mask
    wr(S_OCW3, 8'h0B);
    check("ocw3_isr_sel", read_register_isr_or_irr, 1'b1);
    read = 1'b1;
    tick();
    check("ocw3_read_en", enable_read_register, 1'b1);
    read = 1'b0;
    wr(S_OCW1, 8'hF0);
    wr(S_OCW3, 8'h68);
    check("ocw1_mask", interrupt_mask, 8'hF0);
    check("smm_mask",  interrupt_special_mask, 8'hF0);

    // Poll command followed by a read
    wr(S_OCW3, 8'h0C);
    interrupt = 8'h04;
    read = 1'b1;
    tick();
    check("poll_out",   out_control_logic_data, 1'b1);
    check("poll_byte",  control_logic_data, 8'h82);
    check("poll_latch", latch_in_service, 1'b1);
    check("poll_clr",   clear_interrupt_request, 8'h04);
    check("poll_no_rd", enable_read_register, 1'b0);
    read = 1'b0;
    interrupt = 8'h00;
    tick();
    check("poll_done", out_control_logic_data, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
